// File: rtl/bpred_update_ctrl_if.sv
// bpred_update_ctrl_if: fetch lookup, branch resolve and counter-table signals of the update controller
interface bpred_update_ctrl_if #(parameter int BPRED_WIDTH = 10);
    logic                   i_Lookup_Valid;
    logic [31:0]            i_Lookup_PC;
    logic                   i_CT_Prediction;
    logic                   o_Prediction;
    logic                   o_Lookup_Stall;
    logic [BPRED_WIDTH-1:0] o_Lookup_GHR;
    logic                   i_Resolve_Valid;
    logic [31:0]            i_Resolve_PC;
    logic [BPRED_WIDTH-1:0] i_Resolve_GHR;
    logic                   i_Resolve_Outcome;
    logic                   i_Resolve_Mispredict;
    logic                   o_Resolve_Ready;
    logic [BPRED_WIDTH-1:0] o_CT_Index;
    logic                   o_CT_Outcome;
    logic                   o_CT_Enable;
    logic [BPRED_WIDTH-1:0] o_GHR;
    modport slave (
        input  i_Lookup_Valid, i_Lookup_PC, i_CT_Prediction,
        input  i_Resolve_Valid, i_Resolve_PC, i_Resolve_GHR, i_Resolve_Outcome, i_Resolve_Mispredict,
        output o_Prediction, o_Lookup_Stall, o_Lookup_GHR, o_Resolve_Ready,
        output o_CT_Index, o_CT_Outcome, o_CT_Enable, o_GHR
    );
    modport master (
        output i_Lookup_Valid, i_Lookup_PC, i_CT_Prediction,
        output i_Resolve_Valid, i_Resolve_PC, i_Resolve_GHR, i_Resolve_Outcome, i_Resolve_Mispredict,
        input  o_Prediction, o_Lookup_Stall, o_Lookup_GHR, o_Resolve_Ready,
        input  o_CT_Index, o_CT_Outcome, o_CT_Enable, o_GHR
    );
endinterface

// File: rtl/bpred_update_ctrl.sv
// bpred_update_ctrl: gshare GHR owner, update FIFO and single-port counter-table arbiter
module bpred_update_ctrl #(
    parameter int BPRED_WIDTH  = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic i_Clk,
    input logic i_Reset,
    bpred_update_ctrl_if.slave bus
);
    localparam int BW = BPRED_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, SETUP, FIRE} state_t;
    state_t state, state_nxt;
    logic [BW-1:0] ghr, idx_r, lookup_idx;
    logic out_r;
    logic [BW:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [SW-1:0] starve;
    logic full, empty, push, leave, serviced, mis, waiting;
    logic unused_pc;
    assign unused_pc = ^{bus.i_Lookup_PC[31:BW+2], bus.i_Lookup_PC[1:0],
                         bus.i_Resolve_PC[31:BW+2], bus.i_Resolve_PC[1:0]};
    assign lookup_idx = bus.i_Lookup_PC[BW+1:2] ^ ghr;
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign push       = bus.i_Resolve_Valid & !full;
    assign mis        = push & bus.i_Resolve_Mispredict;
    assign waiting    = state == IDLE && !empty && bus.i_Lookup_Valid;
    always_comb begin
        leave     = state == IDLE && !empty && (!bus.i_Lookup_Valid || full || starve == SW'(STARVE_LIMIT));
        state_nxt = leave ? SETUP : state == SETUP ? FIRE : state == FIRE ? IDLE : state;
    end
    // The table index port is shared: lookups own it only in IDLE, updates hold it through SETUP and FIRE
    assign bus.o_CT_Index      = state == IDLE ? lookup_idx : idx_r;
    assign bus.o_CT_Outcome    = state != IDLE & out_r;
    assign bus.o_CT_Enable     = state == FIRE;
    assign bus.o_Prediction    = bus.i_CT_Prediction;
    assign bus.o_Lookup_Stall  = bus.i_Lookup_Valid & (state != IDLE | leave);
    assign bus.o_Lookup_GHR    = ghr;
    assign bus.o_Resolve_Ready = !full;
    assign bus.o_GHR           = ghr;
    assign serviced            = bus.i_Lookup_Valid & !bus.o_Lookup_Stall;
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge i_Clk) begin
        if (push)
            mem[wr_ptr] <= {bus.i_Resolve_PC[BW+1:2] ^ bus.i_Resolve_GHR, bus.i_Resolve_Outcome};
    end
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            ghr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
            idx_r  <= '0;
            out_r  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(leave);
            count  <= count + (AW+1)'(push) - (AW+1)'(leave);
            starve <= leave ? '0 : (waiting && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
            if (leave)
                {idx_r, out_r} <= mem[rd_ptr];
            // A mispredict repair overrides any speculative shift from the same cycle
            ghr <= mis ? {bus.i_Resolve_GHR[BW-2:0], bus.i_Resolve_Outcome}
                 : serviced ? {ghr[BW-2:0], bus.o_Prediction} : ghr;
        end
    end
endmodule

// File: tb/tb_bpred_update_ctrl.sv
// tb_bpred_update_ctrl: directed checks plus a scoreboard of expected counter-table updates
module tb_bpred_update_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [4:0] sb [$];
    bpred_update_ctrl_if #(.BPRED_WIDTH(4)) bus ();
    bpred_update_ctrl #(.BPRED_WIDTH(4), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Every enable pulse must match the oldest accepted resolve
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.o_CT_Enable) begin
            chk("enable_with_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0)
                chk("ct_update", {27'd0, bus.o_CT_Index, bus.o_CT_Outcome}, {27'd0, sb.pop_front()});
        end
    endtask
    task automatic resolve(input logic [31:0] pc, input logic [3:0] g, input logic o, input logic m);
        bus.i_Resolve_Valid      = 1'b1;
        bus.i_Resolve_PC         = pc;
        bus.i_Resolve_GHR        = g;
        bus.i_Resolve_Outcome    = o;
        bus.i_Resolve_Mispredict = m;
        sb.push_back({pc[5:2] ^ g, o});
    endtask
    initial begin
        bus.i_Lookup_Valid = 1'b1;
        bus.i_Lookup_PC = 32'h0;
        bus.i_CT_Prediction = 1'b0;
        bus.i_Resolve_Valid = 1'b0;
        bus.i_Resolve_PC = 32'h0;
        bus.i_Resolve_GHR = 4'h0;
        bus.i_Resolve_Outcome = 1'b0;
        bus.i_Resolve_Mispredict = 1'b0;
        tick();
        tick();
        chk("rst_enable", bus.o_CT_Enable, 0);
        chk("rst_outcome", bus.o_CT_Outcome, 0);
        chk("rst_stall", bus.o_Lookup_Stall, 0);
        chk("rst_ready", bus.o_Resolve_Ready, 1);
        chk("rst_ghr", bus.o_GHR, 0);
        rst = 1'b0;
        bus.i_Lookup_PC = 32'h10;
        bus.i_CT_Prediction = 1'b1;
        #1;
        chk("lookup_index", bus.o_CT_Index, 4);
        chk("lookup_stall", bus.o_Lookup_Stall, 0);
        chk("lookup_pred", bus.o_Prediction, 1);
        chk("lookup_ghr", bus.o_Lookup_GHR, 0);
        tick();
        bus.i_Lookup_Valid = 1'b0;
        bus.i_CT_Prediction = 1'b0;
        chk("ghr_shift", bus.o_GHR, 1);
        resolve(32'h8, 4'h3, 1'b1, 1'b0);
        #1;
        chk("single_ready", bus.o_Resolve_Ready, 1);
        tick();
        bus.i_Resolve_Valid = 1'b0;
        #1;
        chk("single_idle_en", bus.o_CT_Enable, 0);
        tick();
        chk("setup_index", bus.o_CT_Index, 1);
        chk("setup_outcome", bus.o_CT_Outcome, 1);
        chk("setup_en", bus.o_CT_Enable, 0);
        tick();
        chk("fire_en", bus.o_CT_Enable, 1);
        chk("fire_index", bus.o_CT_Index, 1);
        tick();
        chk("after_fire_en", bus.o_CT_Enable, 0);
        chk("ghr_kept", bus.o_GHR, 1);
        bus.i_Lookup_Valid = 1'b1;
        bus.i_Lookup_PC = 32'h0;
        for (int k = 0; k < 4; k++) begin
            resolve(32'(k * 4), 4'h0, k[0], 1'b0);
            #1;
            chk("fill_ready", bus.o_Resolve_Ready, 1);
            chk("fill_stall", bus.o_Lookup_Stall, 0);
            tick();
        end
        bus.i_Resolve_Valid = 1'b0;
        #1;
        chk("full_ready", bus.o_Resolve_Ready, 0);
        chk("full_stall1", bus.o_Lookup_Stall, 1);
        tick();
        chk("full_stall2", bus.o_Lookup_Stall, 1);
        chk("full_ready_back", bus.o_Resolve_Ready, 1);
        tick();
        chk("full_stall3", bus.o_Lookup_Stall, 1);
        tick();
        chk("full_stall_end", bus.o_Lookup_Stall, 0);
        bus.i_Lookup_Valid = 1'b0;
        repeat (10) tick();
        chk("drain_full", 32'(sb.size()), 0);
        bus.i_Lookup_Valid = 1'b1;
        bus.i_Lookup_PC = 32'h20;
        resolve(32'h4, 4'h2, 1'b0, 1'b0);
        tick();
        bus.i_Resolve_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("starve_wait", bus.o_Lookup_Stall, 0);
            tick();
        end
        #1;
        chk("starve_force", bus.o_Lookup_Stall, 1);
        bus.i_Lookup_Valid = 1'b0;
        repeat (3) tick();
        chk("drain_starve", 32'(sb.size()), 0);
        bus.i_Lookup_Valid = 1'b1;
        bus.i_Lookup_PC = 32'h30;
        bus.i_CT_Prediction = 1'b1;
        resolve(32'h0, 4'h5, 1'b0, 1'b1);
        tick();
        chk("repair_ghr_a", bus.o_GHR, 4'hA);
        resolve(32'h0, 4'hA, 1'b1, 1'b1);
        #1;
        chk("mis_lookup_stall", bus.o_Lookup_Stall, 0);
        chk("mis_lookup_ghr", bus.o_Lookup_GHR, 4'hA);
        tick();
        chk("repair_ghr_5", bus.o_GHR, 4'h5);
        bus.i_Lookup_Valid = 1'b0;
        bus.i_CT_Prediction = 1'b0;
        bus.i_Resolve_Valid = 1'b0;
        repeat (7) tick();
        chk("drain_mis", 32'(sb.size()), 0);
        resolve(32'h8, 4'h3, 1'b1, 1'b0);
        tick();
        resolve(32'hC, 4'h0, 1'b0, 1'b0);
        tick();
        bus.i_Resolve_Valid = 1'b0;
        tick();
        chk("pre_rst_fire", bus.o_CT_Enable, 1);
        rst = 1'b1;
        tick();
        chk("midrst_enable", bus.o_CT_Enable, 0);
        chk("midrst_ready", bus.o_Resolve_Ready, 1);
        chk("midrst_ghr", bus.o_GHR, 0);
        sb.delete();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_ready", bus.o_Resolve_Ready, 1);
        chk("post_rst_ghr", bus.o_GHR, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
